// File: rtl/prog_lut_eval_pkg.sv
// Shared definitions for the programmable truth-table evaluator:
// controller state encoding and the table-depth helper.
package lut_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } lut_state_e;

    // Number of table entries addressed by a sel_w-bit input vector.
    function automatic int unsigned lut_depth(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

endpackage

// File: rtl/prog_lut_eval_if.sv
// Config / evaluate bus of prog_lut_eval. The master side drives the load
// and lookup requests, the slave side (the evaluator) answers them.
interface prog_lut_eval_if #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 1
) ();
    logic             cfg_start;
    logic             cfg_valid;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_done;
    logic [OUT_W-1:0] cfg_check;
    logic             cfg_err;
    logic             eval_valid;
    logic [SEL_W-1:0] eval_sel;
    logic             eval_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             busy;

    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_check, eval_valid, eval_sel,
        input  cfg_ready, cfg_done, cfg_err, eval_ready, out_valid, out_data, busy
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_check, eval_valid, eval_sel,
        output cfg_ready, cfg_done, cfg_err, eval_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/prog_lut_eval_cfg_ctrl.sv
// Load controller for prog_lut_eval: EMPTY/LOAD/RUN state machine, the table
// write counter and the done/error pulses.
// Optional build macro LUT_CHECK_EN adds a running XOR over the loaded words
// that must match cfg_check on the final word before the table is usable.
module lut_cfg_ctrl
    import lut_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic [OUT_W-1:0] cfg_check,
    output logic             cfg_ready,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic             busy,
    output logic             eval_ready,
    output logic             wr_en,
    output logic [SEL_W-1:0] wr_idx
);
    localparam int DEPTH = int'(lut_depth(SEL_W));
    localparam int CNT_W = SEL_W + 1;

    lut_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_s;
    logic             wr_en_s;

`ifdef LUT_CHECK_EN
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] sum_s;
    logic             err_q, err_d;
`else
    logic [OUT_W-1:0] cfg_check_unused_s;
    assign cfg_check_unused_s = cfg_check;
`endif

    assign last_s = (cnt_q == CNT_W'(DEPTH - 1));

    // Next-state, counter and pulse logic; cfg_start beats a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wr_en_s = 1'b0;
`ifdef LUT_CHECK_EN
        acc_d   = acc_q;
        err_d   = 1'b0;
        sum_s   = acc_q ^ cfg_data;
`endif
        case (state_q)
            ST_EMPTY, ST_RUN: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = {CNT_W{1'b0}};
`ifdef LUT_CHECK_EN
                    acc_d   = {OUT_W{1'b0}};
`endif
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    cnt_d = {CNT_W{1'b0}};
`ifdef LUT_CHECK_EN
                    acc_d = {OUT_W{1'b0}};
`endif
                end else if (cfg_valid) begin
                    wr_en_s = 1'b1;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef LUT_CHECK_EN
                    acc_d   = sum_s;
`endif
                    if (last_s) begin
`ifdef LUT_CHECK_EN
                        if (sum_s == cfg_check) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_EMPTY;
                            err_d   = 1'b1;
                        end
`else
                        state_d = ST_RUN;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= {CNT_W{1'b0}};
            done_q  <= 1'b0;
`ifdef LUT_CHECK_EN
            acc_q   <= {OUT_W{1'b0}};
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef LUT_CHECK_EN
            acc_q   <= acc_d;
            err_q   <= err_d;
`endif
        end
    end

    assign cfg_ready  = (state_q == ST_LOAD);
    assign busy       = (state_q == ST_LOAD);
    assign eval_ready = (state_q == ST_RUN);
    assign cfg_done   = done_q;
`ifdef LUT_CHECK_EN
    assign cfg_err    = err_q;
`else
    assign cfg_err    = 1'b0;
`endif
    assign wr_en      = wr_en_s;
    assign wr_idx     = cnt_q[SEL_W-1:0];

endmodule

// File: rtl/prog_lut_eval.sv
// Programmable truth-table evaluator: a 2**SEL_W x OUT_W table loaded over the
// config handshake and looked up with a registered, one-per-cycle evaluate
// port. Bit k of every word implements Boolean function k of eval_sel.
// Optional build macro LUT_CHECK_EN enables the load checksum (see lut_cfg_ctrl).
module prog_lut_eval
    import lut_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_W = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    prog_lut_eval_if.slave bus
);
    localparam int DEPTH = int'(lut_depth(SEL_W));

    logic [OUT_W-1:0] table_q [DEPTH];
    logic [OUT_W-1:0] table_d [DEPTH];
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic             wr_en_s;
    logic [SEL_W-1:0] wr_idx_s;
    logic             eval_ready_s;
    logic             eval_hs_s;

    lut_cfg_ctrl #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (bus.cfg_start),
        .cfg_valid  (bus.cfg_valid),
        .cfg_data   (bus.cfg_data),
        .cfg_check  (bus.cfg_check),
        .cfg_ready  (bus.cfg_ready),
        .cfg_done   (bus.cfg_done),
        .cfg_err    (bus.cfg_err),
        .busy       (bus.busy),
        .eval_ready (eval_ready_s),
        .wr_en      (wr_en_s),
        .wr_idx     (wr_idx_s)
    );

    assign eval_hs_s = bus.eval_valid & eval_ready_s;

    // Table write port: one word per accepted config handshake.
    always_comb begin
        table_d = table_q;
        if (wr_en_s) begin
            table_d[wr_idx_s] = bus.cfg_data;
        end else begin
            table_d = table_q;
        end
    end

    // Lookup reads the table as it stood before this edge, so an eval that
    // coincides with cfg_start sees the pre-load contents.
    always_comb begin
        out_valid_d = eval_hs_s;
        if (eval_hs_s) begin
            out_data_d = table_q[bus.eval_sel];
        end else begin
            out_data_d = out_data_q;
        end
    end

    // Table storage and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= {OUT_W{1'b0}};
            end
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
        end else begin
            table_q     <= table_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.eval_ready = eval_ready_s;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;

endmodule

// File: tb/tb_prog_lut_eval.sv
// Scoreboard bench for prog_lut_eval (SEL_W=3, OUT_W=2). The driver pushes the
// expected lookup result whenever it issues an accepted evaluation; a separate
// monitor pops and compares on every out_valid. Covers both builds of LUT_CHECK_EN.
module tb_prog_lut_eval;
    localparam int SEL_W = 3;
    localparam int OUT_W = 2;

    logic clk;
    logic rst_n;

    prog_lut_eval_if #(.SEL_W(SEL_W), .OUT_W(OUT_W)) bus ();

    prog_lut_eval #(.SEL_W(SEL_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [OUT_W-1:0] exp_q [$];
    logic [OUT_W-1:0] mtab [8];
    bit               mrun;
    logic [OUT_W-1:0] lw [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
            else check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        if (bus.cfg_done) done_cnt++;
        if (bus.cfg_err) err_cnt++;
    end

    task automatic eval_one(input logic [SEL_W-1:0] sel, input bit valid);
        bus.eval_valid = valid;
        bus.eval_sel   = sel;
        if (valid && mrun) exp_q.push_back(mtab[sel]);
        step();
        bus.eval_valid = 1'b0;
    endtask

    // Load lw[0..7]; optional leading cfg_start, optional abort after some words.
    task automatic load_table(input bit do_start, input int abort_after, input bit bad_check);
        logic [OUT_W-1:0] x;
        int dc0, ec0;
        bit ok;
        x = '0;
        dc0 = done_cnt;
        ec0 = err_cnt;
        bus.eval_valid = 1'b0;
        if (do_start) begin
            bus.cfg_start = 1'b1;
            bus.cfg_valid = 1'($urandom_range(0, 1));
            bus.cfg_data  = OUT_W'($urandom);
            step();
            bus.cfg_start = 1'b0;
            mrun = 1'b0;
        end
        bus.cfg_valid = 1'b0;
        check("load_entry", 32'({bus.busy, bus.cfg_ready, bus.eval_ready}), 32'b110);
        if (abort_after >= 0) begin
            for (int i = 0; i < abort_after; i++) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_data  = OUT_W'($urandom);
                step();
            end
            bus.cfg_start = 1'b1;
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = OUT_W'($urandom);
            step();
            bus.cfg_start = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.cfg_valid = 1'b0;
                step();
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = lw[i];
            x = x ^ lw[i];
            bus.cfg_check = (i == 7) ? (bad_check ? (x ^ 2'b01) : x) : OUT_W'($urandom);
            step();
        end
        bus.cfg_valid = 1'b0;
`ifdef LUT_CHECK_EN
        ok = !bad_check;
`else
        ok = 1'b1;
`endif
        check("cfg_done_pulse", 32'(bus.cfg_done), 32'(ok));
        check("cfg_err_pulse", 32'(bus.cfg_err), 32'(!ok));
        check("eval_ready_post_load", 32'(bus.eval_ready), 32'(ok));
        check("busy_post_load", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 8; i++) mtab[i] = lw[i];
        mrun = ok;
        step();
        check("cfg_done_low", 32'({bus.cfg_done, bus.cfg_err}), 32'd0);
        check("done_count", 32'(done_cnt - dc0), 32'(ok));
        check("err_count", 32'(err_cnt - ec0), 32'(!ok));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0; bus.cfg_check = '0;
        bus.eval_valid = 1'b0; bus.eval_sel = '0;
        mrun = 1'b0;
        for (int i = 0; i < 8; i++) mtab[i] = '0;
        step(); step();
        check("reset_outputs", 32'({bus.cfg_ready, bus.cfg_done, bus.cfg_err, bus.eval_ready,
                                     bus.out_valid, bus.out_data, bus.busy}), 32'd0);
        rst_n = 1'b1;

        // Empty table: evaluations are refused.
        bus.eval_valid = 1'b1; bus.eval_sel = 3'd0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("eval_ready_empty", 32'(bus.eval_ready), 32'd0);
        end
        bus.eval_valid = 1'b0;
        check("idle_outputs", 32'({bus.cfg_ready, bus.cfg_done, bus.cfg_err, bus.eval_ready,
                                   bus.out_valid, bus.out_data, bus.busy}), 32'd0);

        // One function of three inputs.
        lw = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        load_table(1'b1, -1, 1'b0);
        eval_one(3'd4, 1'b1);
        eval_one(3'd2, 1'b1);
        for (int s = 0; s < 8; s++) eval_one(3'(s), 1'b1);

        // Two functions per entry.
        lw = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10};
        load_table(1'b1, -1, 1'b0);
        eval_one(3'd3, 1'b1);
        eval_one(3'd6, 1'b1);
        eval_one(3'd4, 1'b1);
        eval_one(3'd0, 1'b1);

        // Abort after three words, then a full reload of ones.
        lw = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        load_table(1'b1, 3, 1'b0);
        for (int s = 0; s < 8; s++) eval_one(3'(s), 1'b1);

        // cfg_start together with an eval in RUN: old table[3] is returned.
        bus.cfg_start = 1'b1;
        eval_one(3'd3, 1'b1);
        bus.cfg_start = 1'b0;
        mrun = 1'b0;
        check("start_eval_state", 32'({bus.busy, bus.eval_ready}), 32'b10);
        for (int i = 0; i < 8; i++) lw[i] = OUT_W'($urandom);
        load_table(1'b0, -1, 1'b0);
        eval_one(3'd3, 1'b1);
        eval_one(3'd5, 1'b1);

        // Checksum mismatch (only rejected when the checksum is built in).
        lw = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        load_table(1'b1, -1, 1'b1);
        eval_one(3'd0, 1'b1);
        eval_one(3'd4, 1'b1);
        load_table(1'b1, -1, 1'b0);
        eval_one(3'd4, 1'b1);

        // Reset in the middle of a load.
        bus.cfg_start = 1'b1;
        step();
        bus.cfg_start = 1'b0;
        mrun = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data  = OUT_W'($urandom);
            step();
        end
        bus.cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midload_reset", 32'({bus.busy, bus.cfg_ready, bus.eval_ready, bus.cfg_done}), 32'd0);
        for (int i = 0; i < 8; i++) mtab[i] = '0;
        step();
        rst_n = 1'b1;
        step();
        check("eval_ready_after_reset", 32'(bus.eval_ready), 32'd0);
        eval_one(3'd1, 1'b1);

        // Randomised loads (some aborted) and lookups.
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 8; i++) lw[i] = OUT_W'($urandom);
            load_table(1'b1, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 7)), 1'b0);
            for (int e = 0; e < 24; e++) eval_one(SEL_W'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        bus.eval_valid = 1'b0;
        step(); step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
